// File: rtl/cg_timer_ctrl.sv
// Timer controller: sequences a downstream counter through preset/run/pause and raises an expiry irq.
// Optional expiry counter output o_exp_cnt is enabled by defining CG_TIMER_CTRL_EXP_CNT_EN.
module cg_timer_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_pause,
    input  logic                  i_abort,
    input  logic                  i_periodic,
    input  logic [DATA_WIDTH-1:0] i_load,
    input  logic [DATA_WIDTH-1:0] i_cmp,
    input  logic [DATA_WIDTH-1:0] i_count,
    input  logic                  i_irq_ready,
    output logic                  o_prst,
    output logic                  o_stop,
    output logic [DATA_WIDTH-1:0] o_default,
    output logic                  o_irq_valid,
    output logic                  o_irq_ovf,
    output logic [2:0]            o_state
`ifdef CG_TIMER_CTRL_EXP_CNT_EN
    ,
    output logic [7:0]            o_exp_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] load_q;
    logic [DATA_WIDTH-1:0] cmp_q;
    logic                  periodic_q;
    logic                  prst_q;
    logic                  stop_q;
    logic                  irq_valid_q, irq_valid_d;
    logic                  irq_ovf_q, irq_ovf_d;
    logic                  expire;
    logic                  accept;

    // Expiry is seen only while running; abort wins the state transition but the irq is still raised.
    assign expire = (state_q == ST_RUN) && (i_count == cmp_q);
    assign accept = i_start && !i_abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (i_start) state_d = ST_LOAD;
                ST_LOAD:          state_d = ST_RUN;
                ST_RUN: begin
                    if (expire)       state_d = periodic_q ? ST_LOAD : ST_DONE;
                    else if (i_pause) state_d = ST_PAUSE;
                end
                ST_PAUSE:         if (!i_pause) state_d = ST_RUN;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        irq_valid_d = expire || (irq_valid_q && !i_irq_ready);
        irq_ovf_d   = accept ? 1'b0 : (irq_ovf_q || (expire && irq_valid_q && !i_irq_ready));
    end

    // Preset/hold are registered alongside the state so they always match o_state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            load_q      <= '0;
            cmp_q       <= '0;
            periodic_q  <= 1'b0;
            prst_q      <= 1'b0;
            stop_q      <= 1'b1;
            irq_valid_q <= 1'b0;
            irq_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prst_q      <= (state_d == ST_LOAD);
            stop_q      <= (state_d == ST_IDLE) || (state_d == ST_PAUSE) || (state_d == ST_DONE);
            irq_valid_q <= irq_valid_d;
            irq_ovf_q   <= irq_ovf_d;
            if (accept) begin
                load_q     <= i_load;
                cmp_q      <= i_cmp;
                periodic_q <= i_periodic;
            end
        end
    end

`ifdef CG_TIMER_CTRL_EXP_CNT_EN
    logic [7:0] exp_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            exp_cnt_q <= 8'd0;
        end else if (accept) begin
            exp_cnt_q <= 8'd0;
        end else if (expire && (exp_cnt_q != 8'd255)) begin
            exp_cnt_q <= exp_cnt_q + 8'd1;
        end
    end

    assign o_exp_cnt = exp_cnt_q;
`endif

    assign o_state     = state_q;
    assign o_prst      = prst_q;
    assign o_stop      = stop_q;
    assign o_default   = load_q;
    assign o_irq_valid = irq_valid_q;
    assign o_irq_ovf   = irq_ovf_q;

endmodule
